// File: rtl/ahb_host_mailbox_pkg.sv
// Shared definitions for ahb_host_mailbox: register offsets, STATUS bit layout,
// AHB encodings and the data-phase FSM states.
package ahb_host_mailbox_pkg;

    localparam logic [31:0] OFF_TOHOST   = 32'h00;
    localparam logic [31:0] OFF_FROMHOST = 32'h04;
    localparam logic [31:0] OFF_STATUS   = 32'h08;
    localparam logic [31:0] OFF_SIG_BGN  = 32'h0C;
    localparam logic [31:0] OFF_SIG_END  = 32'h10;

    localparam int unsigned STAT_DONE          = 0;
    localparam int unsigned STAT_PASS          = 1;
    localparam int unsigned STAT_TOHOST_VALID  = 2;
    localparam int unsigned STAT_FROMHOST_FULL = 3;
    localparam int unsigned STAT_IRQ           = 4;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_e;

endpackage

// File: rtl/ahb_host_mailbox_regs.sv
// Mailbox register file: TOHOST handshake, sticky done/pass, FROMHOST, signature range.
// Defining HOST_MAILBOX_IRQ_EN adds the registered FROMHOST-nonempty interrupt (STATUS[4]).
module ahb_host_mailbox_regs
    import ahb_host_mailbox_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = 5,
    parameter logic [31:0] SIG_RESET_BGN = 32'h0,
    parameter logic [31:0] SIG_RESET_END = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o,
    input  logic                 tohost_ready_i,
    output logic                 tohost_valid_o,
    output logic [31:0]          tohost_data_o,
    input  logic                 fromhost_valid_i,
    input  logic [31:0]          fromhost_in_i,
    output logic                 fromhost_ready_o,
    output logic                 test_done_o,
    output logic                 test_pass_o,
    output logic [31:0]          sig_bgn_o,
    output logic [31:0]          sig_end_o
`ifdef HOST_MAILBOX_IRQ_EN
    ,
    output logic                 irq_o
`endif
);

    localparam logic [ADDR_BITS-1:0] A_TOHOST   = ADDR_BITS'(OFF_TOHOST);
    localparam logic [ADDR_BITS-1:0] A_FROMHOST = ADDR_BITS'(OFF_FROMHOST);
    localparam logic [ADDR_BITS-1:0] A_STATUS   = ADDR_BITS'(OFF_STATUS);
    localparam logic [ADDR_BITS-1:0] A_SIG_BGN  = ADDR_BITS'(OFF_SIG_BGN);
    localparam logic [ADDR_BITS-1:0] A_SIG_END  = ADDR_BITS'(OFF_SIG_END);

    logic        tohost_valid_q, tohost_valid_d;
    logic [31:0] tohost_q, tohost_d;
    logic [31:0] fromhost_q, fromhost_d;
    logic [31:0] sig_bgn_q, sig_bgn_d;
    logic [31:0] sig_end_q, sig_end_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        irq_q;
    logic [31:0] status;

    always_comb begin
        tohost_valid_d = tohost_valid_q;
        tohost_d       = tohost_q;
        fromhost_d     = fromhost_q;
        sig_bgn_d      = sig_bgn_q;
        sig_end_d      = sig_end_q;
        done_d         = done_q;
        pass_d         = pass_q;
        if (tohost_valid_q && tohost_ready_i) tohost_valid_d = 1'b0;
        if (fromhost_valid_i && fromhost_q == '0) fromhost_d = fromhost_in_i;
        // CPU writes come last so they override a same-cycle handshake or host load.
        if (wr_en_i) begin
            case (addr_i)
                A_TOHOST: begin
                    tohost_d       = wdata_i;
                    tohost_valid_d = 1'b1;
                    if (wdata_i[0] && !done_q) begin
                        done_d = 1'b1;
                        pass_d = (wdata_i == 32'h1);
                    end
                end
                A_FROMHOST: fromhost_d = wdata_i;
                A_SIG_BGN:  sig_bgn_d  = wdata_i;
                A_SIG_END:  sig_end_d  = wdata_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tohost_valid_q <= 1'b0;
            tohost_q       <= '0;
            fromhost_q     <= '0;
            sig_bgn_q      <= SIG_RESET_BGN;
            sig_end_q      <= SIG_RESET_END;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
        end else begin
            tohost_valid_q <= tohost_valid_d;
            tohost_q       <= tohost_d;
            fromhost_q     <= fromhost_d;
            sig_bgn_q      <= sig_bgn_d;
            sig_end_q      <= sig_end_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
        end
    end

`ifdef HOST_MAILBOX_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= (fromhost_q != '0);
    end
    assign irq_o = irq_q;
`else
    assign irq_q = 1'b0;
`endif

    always_comb begin
        status                     = '0;
        status[STAT_DONE]          = done_q;
        status[STAT_PASS]          = pass_q;
        status[STAT_TOHOST_VALID]  = tohost_valid_q;
        status[STAT_FROMHOST_FULL] = (fromhost_q != '0);
        status[STAT_IRQ]           = irq_q;
        rdata_o = '0;
        case (addr_i)
            A_TOHOST:   rdata_o = tohost_q;
            A_FROMHOST: rdata_o = fromhost_q;
            A_STATUS:   rdata_o = status;
            A_SIG_BGN:  rdata_o = sig_bgn_q;
            A_SIG_END:  rdata_o = sig_end_q;
            default:    rdata_o = '0;
        endcase
    end

    assign tohost_valid_o   = tohost_valid_q;
    assign tohost_data_o    = tohost_q;
    assign fromhost_ready_o = (fromhost_q == '0);
    assign test_done_o      = done_q;
    assign test_pass_o      = pass_q;
    assign sig_bgn_o        = sig_bgn_q;
    assign sig_end_o        = sig_end_q;

endmodule

// File: rtl/ahb_host_mailbox.sv
// AHB-Lite tohost/fromhost mailbox slave: address capture and data-phase FSM.
// Defining HOST_MAILBOX_IRQ_EN adds the IRQ_FROMHOST output.
module ahb_host_mailbox
    import ahb_host_mailbox_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = 5,
    parameter logic [31:0] SIG_RESET_BGN = 32'h0,
    parameter logic [31:0] SIG_RESET_END = 32'h0
) (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic        S_HSEL,
    input  logic [1:0]  S_HTRANS,
    input  logic        S_HWRITE,
    input  logic [2:0]  S_HSIZE,
    input  logic [31:0] S_HADDR,
    input  logic [31:0] S_HWDATA,
    input  logic        S_HREADY,
    output logic        S_HREADYOUT,
    output logic [31:0] S_HRDATA,
    output logic        S_HRESP,
    output logic        TOHOST_VALID,
    input  logic        TOHOST_READY,
    output logic [31:0] TOHOST_DATA,
    input  logic        FROMHOST_VALID,
    output logic        FROMHOST_READY,
    input  logic [31:0] FROMHOST_IN,
    output logic        TEST_DONE,
    output logic        TEST_PASS,
    output logic [31:0] SIG_BGN_OUT,
    output logic [31:0] SIG_END_OUT
`ifdef HOST_MAILBOX_IRQ_EN
    ,
    output logic        IRQ_FROMHOST
`endif
);

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 write_q;
    logic [2:0]           size_q;
    logic                 capture, stall, wr_en, rd_en;
    logic [31:0]          rd_data;
    logic                 unused_haddr;

    assign unused_haddr = ^S_HADDR[31:ADDR_BITS];

    // Pipelined address phases are only taken while this slave is not stalling.
    assign capture = S_HSEL && (S_HTRANS inside {HTRANS_NONSEQ, HTRANS_SEQ})
                     && S_HREADY && S_HREADYOUT;
    assign stall   = write_q && (addr_q == ADDR_BITS'(OFF_TOHOST))
                     && TOHOST_VALID && !TOHOST_READY;

    // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else if (capture) begin
            addr_q  <= S_HADDR[ADDR_BITS-1:0];
            write_q <= S_HWRITE;
            size_q  <= S_HSIZE;
        end
    end

    // NOTE: assign a default before the case so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = capture ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: begin
                if (size_q != HSIZE_WORD) state_d = ST_ERR1;
                else if (stall)           state_d = ST_WAIT;
                else                      state_d = capture ? ST_ACCESS : ST_IDLE;
            end
            ST_WAIT:   if (TOHOST_READY) state_d = capture ? ST_ACCESS : ST_IDLE;
            ST_ERR1:   state_d = ST_ERR2;
            ST_ERR2:   state_d = capture ? ST_ACCESS : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        S_HREADYOUT = 1'b1;
        S_HRESP     = HRESP_OKAY;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        case (state_q)
            ST_ACCESS: begin
                if (size_q != HSIZE_WORD || stall) begin
                    S_HREADYOUT = 1'b0;
                end else begin
                    wr_en = write_q;
                    rd_en = !write_q;
                end
            end
            ST_WAIT: begin
                S_HREADYOUT = TOHOST_READY;
                wr_en       = TOHOST_READY;
            end
            ST_ERR1: begin
                S_HREADYOUT = 1'b0;
                S_HRESP     = HRESP_ERROR;
            end
            ST_ERR2: S_HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    assign S_HRDATA = rd_en ? rd_data : '0;

    ahb_host_mailbox_regs #(
        .ADDR_BITS     (ADDR_BITS),
        .SIG_RESET_BGN (SIG_RESET_BGN),
        .SIG_RESET_END (SIG_RESET_END)
    ) u_regs (
        .clk              (CLK),
        .rst_n            (RES_N),
        .wr_en_i          (wr_en),
        .addr_i           (addr_q),
        .wdata_i          (S_HWDATA),
        .rdata_o          (rd_data),
        .tohost_ready_i   (TOHOST_READY),
        .tohost_valid_o   (TOHOST_VALID),
        .tohost_data_o    (TOHOST_DATA),
        .fromhost_valid_i (FROMHOST_VALID),
        .fromhost_in_i    (FROMHOST_IN),
        .fromhost_ready_o (FROMHOST_READY),
        .test_done_o      (TEST_DONE),
        .test_pass_o      (TEST_PASS),
        .sig_bgn_o        (SIG_BGN_OUT),
        .sig_end_o        (SIG_END_OUT)
`ifdef HOST_MAILBOX_IRQ_EN
        ,
        .irq_o            (IRQ_FROMHOST)
`endif
    );

endmodule

// File: tb/tb_ahb_host_mailbox.sv
// Self-checking bench for ahb_host_mailbox: vector table, corner-case sequences and
// randomized transfers against a register-level model. Honours HOST_MAILBOX_IRQ_EN.
module tb_ahb_host_mailbox;

    localparam logic [31:0] SIG_BGN_P = 32'h8000_1000;
    localparam logic [31:0] SIG_END_P = 32'h8000_2000;
`ifdef HOST_MAILBOX_IRQ_EN
    localparam logic [31:0] IRQ_BIT = 32'h10;
`else
    localparam logic [31:0] IRQ_BIT = 32'h0;
`endif

    logic        CLK = 1'b0;
    logic        RES_N = 1'b1;
    logic        S_HSEL = 1'b0;
    logic [1:0]  S_HTRANS = 2'b00;
    logic        S_HWRITE = 1'b0;
    logic [2:0]  S_HSIZE = 3'b010;
    logic [31:0] S_HADDR = '0;
    logic [31:0] S_HWDATA = '0;
    logic        S_HREADY;
    logic        S_HREADYOUT;
    logic [31:0] S_HRDATA;
    logic        S_HRESP;
    logic        TOHOST_VALID;
    logic        TOHOST_READY = 1'b1;
    logic [31:0] TOHOST_DATA;
    logic        FROMHOST_VALID = 1'b0;
    logic        FROMHOST_READY;
    logic [31:0] FROMHOST_IN = '0;
    logic        TEST_DONE, TEST_PASS;
    logic [31:0] SIG_BGN_OUT, SIG_END_OUT;
`ifdef HOST_MAILBOX_IRQ_EN
    logic        IRQ_FROMHOST;
`endif

    int checks = 0;
    int failures = 0;

    assign S_HREADY = S_HREADYOUT;
    always #5 CLK = ~CLK;

    ahb_host_mailbox #(
        .ADDR_BITS(5), .SIG_RESET_BGN(SIG_BGN_P), .SIG_RESET_END(SIG_END_P)
    ) dut (
        .CLK(CLK), .RES_N(RES_N), .S_HSEL(S_HSEL), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
        .S_HSIZE(S_HSIZE), .S_HADDR(S_HADDR), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
        .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA), .S_HRESP(S_HRESP),
        .TOHOST_VALID(TOHOST_VALID), .TOHOST_READY(TOHOST_READY), .TOHOST_DATA(TOHOST_DATA),
        .FROMHOST_VALID(FROMHOST_VALID), .FROMHOST_READY(FROMHOST_READY), .FROMHOST_IN(FROMHOST_IN),
        .TEST_DONE(TEST_DONE), .TEST_PASS(TEST_PASS), .SIG_BGN_OUT(SIG_BGN_OUT), .SIG_END_OUT(SIG_END_OUT)
`ifdef HOST_MAILBOX_IRQ_EN
        , .IRQ_FROMHOST(IRQ_FROMHOST)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_waits;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RES_N = 1'b0;
        S_HSEL = 1'b0; S_HTRANS = 2'b00; TOHOST_READY = 1'b1; FROMHOST_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RES_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    // Single non-pipelined transfer; starts and ends 1 time unit after a rising edge.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int waits);
        logic fin;
        S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HADDR = addr; S_HWRITE = wr; S_HSIZE = size;
        @(posedge CLK); #1;
        S_HSEL = 1'b0; S_HTRANS = 2'b00; S_HWDATA = wdata;
        fin = 1'b0; err = 1'b0; waits = 0; rdata = '0;
        for (int n = 0; n < 64 && !fin; n++) begin
            @(negedge CLK);
            if (S_HRESP) err = 1'b1;
            if (S_HREADYOUT) begin
                fin = 1'b1;
                rdata = S_HRDATA;
            end else begin
                waits++;
            end
            @(posedge CLK); #1;
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL xfer_timeout: addr 0x%08h still stalled, required completion in 64 cycles", addr);
        end
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] data, input string name);
        logic [31:0] rd; logic e; int w;
        xfer(addr, 1'b1, 3'b010, data, rd, e, w);
        check({name, "_err"}, 32'(e), 32'h0);
        check({name, "_waits"}, 32'(w), 32'h0);
    endtask

    task automatic rd32(input logic [31:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] rd; logic e; int w;
        xfer(addr, 1'b0, 3'b010, 32'h0, rd, e, w);
        check({name, "_err"}, 32'(e), 32'h0);
        check(name, rd, exp);
    endtask

    // Reference model state for the randomized phase.
    logic [31:0] m_tohost, m_fromhost, m_bgn, m_end;
    logic        m_done, m_pass;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, exp, hi, wd, off;
        logic e, wr;
        logic [2:0] sz;
        int w, k;
        logic [31:0] offs [7] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h1C};
        logic [2:0]  bad_sizes [3] = '{3'b000, 3'b001, 3'b011};

        vecs.push_back('{32'h0C, 1'b0, 3'b010, 32'h0, SIG_BGN_P, 1'b0, 0});
        vecs.push_back('{32'h10, 1'b0, 3'b010, 32'h0, SIG_END_P, 1'b0, 0});
        vecs.push_back('{32'h08, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 0});
        vecs.push_back('{32'h00, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 0});
        vecs.push_back('{32'h0C, 1'b1, 3'b010, 32'h1234_5678, 32'h0, 1'b0, 0});
        vecs.push_back('{32'h0C, 1'b0, 3'b010, 32'h0, 32'h1234_5678, 1'b0, 0});
        vecs.push_back('{32'h0C, 1'b1, 3'b001, 32'h0000_DEAD, 32'h0, 1'b1, 2});
        vecs.push_back('{32'h0C, 1'b0, 3'b010, 32'h0, 32'h1234_5678, 1'b0, 0});
        vecs.push_back('{32'h0C, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 2});
        vecs.push_back('{32'h14, 1'b1, 3'b010, 32'hFFFF_FFFF, 32'h0, 1'b0, 0});
        vecs.push_back('{32'h14, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 0});
        vecs.push_back('{32'h08, 1'b1, 3'b010, 32'hFFFF_FFFF, 32'h0, 1'b0, 0});
        vecs.push_back('{32'h08, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 0});
        vecs.push_back('{32'h04, 1'b1, 3'b010, 32'h0000_0055, 32'h0, 1'b0, 0});
        vecs.push_back('{32'h04, 1'b0, 3'b010, 32'h0, 32'h0000_0055, 1'b0, 0});
        vecs.push_back('{32'h08, 1'b0, 3'b010, 32'h0, 32'h8 | IRQ_BIT, 1'b0, 0});
        vecs.push_back('{32'h04, 1'b1, 3'b010, 32'h0, 32'h0, 1'b0, 0});
        vecs.push_back('{32'h08, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 0});
        vecs.push_back('{32'h10, 1'b1, 3'b010, 32'hCAFE_F00D, 32'h0, 1'b0, 0});
        vecs.push_back('{32'h10, 1'b0, 3'b010, 32'h0, 32'hCAFE_F00D, 1'b0, 0});
        vecs.push_back('{32'h00, 1'b1, 3'b011, 32'h1, 32'h0, 1'b1, 2});
        vecs.push_back('{32'h08, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 0});
        vecs.push_back('{32'h1C, 1'b1, 3'b010, 32'h0BAD_BEEF, 32'h0, 1'b0, 0});
        vecs.push_back('{32'h1C, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 0});

        // Reset values
        do_reset();
        @(negedge CLK);
        check("rst_hreadyout", 32'(S_HREADYOUT), 32'h1);
        check("rst_hresp", 32'(S_HRESP), 32'h0);
        check("rst_hrdata", S_HRDATA, 32'h0);
        check("rst_tohost_valid", 32'(TOHOST_VALID), 32'h0);
        check("rst_tohost_data", TOHOST_DATA, 32'h0);
        check("rst_fromhost_ready", 32'(FROMHOST_READY), 32'h1);
        check("rst_done_pass", {30'h0, TEST_PASS, TEST_DONE}, 32'h0);
        check("rst_sig_bgn", SIG_BGN_OUT, SIG_BGN_P);
        check("rst_sig_end", SIG_END_OUT, SIG_END_P);
        @(posedge CLK); #1;

        // Vector table
        foreach (vecs[i]) begin
            xfer(vecs[i].addr, vecs[i].wr, vecs[i].size, vecs[i].wdata, rd, e, w);
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_waits", i), 32'(w), 32'(vecs[i].exp_waits));
            if (!vecs[i].wr && !vecs[i].exp_err)
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end
        check("tab_sig_bgn_pin", SIG_BGN_OUT, 32'h1234_5678);
        check("tab_sig_end_pin", SIG_END_OUT, 32'hCAFE_F00D);
        check("tab_done_pin", 32'(TEST_DONE), 32'h0);

        // Passing signature write
        do_reset();
        wr32(32'h00, 32'h1, "pass_wr");
        check("pass_valid_pulse", 32'(TOHOST_VALID), 32'h1);
        check("pass_data", TOHOST_DATA, 32'h1);
        check("pass_done_pass", {30'h0, TEST_PASS, TEST_DONE}, 32'h3);
        @(posedge CLK); #1;
        check("pass_valid_cleared", 32'(TOHOST_VALID), 32'h0);
        rd32(32'h08, 32'h3, "pass_status");

        // Failing code is sticky; a later 1 does not turn it into a pass
        do_reset();
        wr32(32'h00, 32'h0000_002B, "fail_wr");
        check("fail_done_pass", {30'h0, TEST_PASS, TEST_DONE}, 32'h1);
        wr32(32'h00, 32'h1, "fail_wr1");
        check("fail_sticky", {30'h0, TEST_PASS, TEST_DONE}, 32'h1);
        rd32(32'h08, 32'h1, "fail_status");

        // Back-to-back TOHOST writes with the host not ready
        do_reset();
        TOHOST_READY = 1'b0;
        S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HADDR = 32'h0; S_HWRITE = 1'b1; S_HSIZE = 3'b010;
        @(posedge CLK); #1;
        S_HWDATA = 32'h10;
        @(negedge CLK);
        check("b2b_first_ready", 32'(S_HREADYOUT), 32'h1);
        @(posedge CLK); #1;
        S_HSEL = 1'b0; S_HTRANS = 2'b00; S_HWDATA = 32'h20;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("b2b_stall", 32'(S_HREADYOUT), 32'h0);
            @(posedge CLK); #1;
        end
        check("b2b_hold_data", TOHOST_DATA, 32'h10);
        check("b2b_hold_valid", 32'(TOHOST_VALID), 32'h1);
        TOHOST_READY = 1'b1;
        @(negedge CLK);
        check("b2b_release", 32'(S_HREADYOUT), 32'h1);
        @(posedge CLK); #1;
        check("b2b_data2", TOHOST_DATA, 32'h20);
        check("b2b_valid2", 32'(TOHOST_VALID), 32'h1);
        @(posedge CLK); #1;
        check("b2b_valid_done", 32'(TOHOST_VALID), 32'h0);

        // Host mailbox direction
        do_reset();
        FROMHOST_IN = 32'hA5; FROMHOST_VALID = 1'b1;
        @(negedge CLK);
        check("fh_ready_empty", 32'(FROMHOST_READY), 32'h1);
        @(posedge CLK); #1;
        FROMHOST_VALID = 1'b0;
        check("fh_ready_full", 32'(FROMHOST_READY), 32'h0);
        @(posedge CLK); #1;
`ifdef HOST_MAILBOX_IRQ_EN
        check("fh_irq_set", 32'(IRQ_FROMHOST), 32'h1);
`endif
        rd32(32'h04, 32'hA5, "fh_read");
        wr32(32'h04, 32'h0, "fh_ack");
        check("fh_ready_again", 32'(FROMHOST_READY), 32'h1);
        @(posedge CLK); #1;
`ifdef HOST_MAILBOX_IRQ_EN
        check("fh_irq_clr", 32'(IRQ_FROMHOST), 32'h0);
`endif

        // Reset while a TOHOST write is stalled
        do_reset();
        TOHOST_READY = 1'b0;
        wr32(32'h00, 32'h0000_0077, "rw_first");
        S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HADDR = 32'h0; S_HWRITE = 1'b1; S_HSIZE = 3'b010;
        @(posedge CLK); #1;
        S_HSEL = 1'b0; S_HTRANS = 2'b00; S_HWDATA = 32'h0000_0099;
        repeat (2) @(posedge CLK);
        #1;
        check("rw_in_wait", 32'(S_HREADYOUT), 32'h0);
        RES_N = 1'b0;
        #1;
        check("rw_rst_hreadyout", 32'(S_HREADYOUT), 32'h1);
        check("rw_rst_hresp", 32'(S_HRESP), 32'h0);
        check("rw_rst_valid", 32'(TOHOST_VALID), 32'h0);
        check("rw_rst_data", TOHOST_DATA, 32'h0);
        TOHOST_READY = 1'b1;
        @(posedge CLK); #1;
        RES_N = 1'b1;
        @(posedge CLK); #1;
        wr32(32'h0C, 32'h55, "rw_after_wr");
        rd32(32'h0C, 32'h55, "rw_after_rd");
        check("rw_pending_dropped", TOHOST_DATA, 32'h0);

        // Randomized transfers against the register-level model
        do_reset();
        m_tohost = '0; m_fromhost = '0; m_bgn = SIG_BGN_P; m_end = SIG_END_P;
        m_done = 1'b0; m_pass = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(3) == 0) begin
                FROMHOST_IN = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
                FROMHOST_VALID = 1'b1;
                @(posedge CLK); #1;
                FROMHOST_VALID = 1'b0;
                if (m_fromhost == '0) m_fromhost = FROMHOST_IN;
            end
            off = offs[$urandom_range(6)];
            hi = $urandom;
            wr = 1'($urandom_range(1));
            sz = ($urandom_range(5) == 0) ? bad_sizes[$urandom_range(2)] : 3'b010;
            k = $urandom_range(3);
            case (k)
                0:       wd = 32'h1;
                1:       wd = $urandom | 32'h1;
                2:       wd = 32'h0;
                default: wd = $urandom;
            endcase
            xfer({hi[31:5], off[4:0]}, wr, sz, wd, rd, e, w);
            check("rnd_err", 32'(e), 32'(sz != 3'b010));
            check("rnd_waits", 32'(w), (sz != 3'b010) ? 32'h2 : 32'h0);
            if (sz == 3'b010 && !wr) begin
                case (off)
                    32'h00:  exp = m_tohost;
                    32'h04:  exp = m_fromhost;
                    32'h08:  exp = {27'h0, (m_fromhost != 0) && (IRQ_BIT != 0), m_fromhost != 0,
                                    1'b0, m_pass, m_done};
                    32'h0C:  exp = m_bgn;
                    32'h10:  exp = m_end;
                    default: exp = 32'h0;
                endcase
                check("rnd_rdata", rd, exp);
            end else if (sz == 3'b010 && wr) begin
                case (off)
                    32'h00: begin
                        m_tohost = wd;
                        if (wd[0] && !m_done) begin
                            m_done = 1'b1;
                            m_pass = (wd == 32'h1);
                        end
                    end
                    32'h04:  m_fromhost = wd;
                    32'h0C:  m_bgn = wd;
                    32'h10:  m_end = wd;
                    default: ;
                endcase
            end
            check("rnd_tohost_pin", TOHOST_DATA, m_tohost);
            check("rnd_done_pass", {30'h0, TEST_PASS, TEST_DONE}, {30'h0, m_pass, m_done});
            check("rnd_fh_ready", 32'(FROMHOST_READY), 32'(m_fromhost == 0));
            check("rnd_sig_pins", SIG_BGN_OUT ^ SIG_END_OUT, m_bgn ^ m_end);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_host_mailbox.md
Name: ahb_host_mailbox

Overview:
AHB-Lite slave that gives compliance and self-test programs a `tohost`/`fromhost` mailbox implemented in hardware. CPU writes to TOHOST are forwarded to a host agent through a valid/ready handshake. Writes with bit0=1 latch a sticky done/pass status. The block also holds the signature begin/end addresses so a host or debugger can dump results without hierarchical peeking. It sits on the data-side AHB matrix as one slave, next to RAMI.

Parameters:
ADDR_BITS, 5, number of low HADDR bits decoded as register offset
SIG_RESET_BGN, 32'h0, reset value of SIG_BGN
SIG_RESET_END, 32'h0, reset value of SIG_END

Ports:
CLK  in  1  system clock
RES_N  in  1  asynchronous active-low reset
S_HSEL  in  1  slave select
S_HTRANS  in  2  transfer type
S_HWRITE  in  1  write
S_HSIZE  in  3  transfer size
S_HADDR  in  32  address
S_HWDATA  in  32  write data
S_HREADY  in  1  bus ready (previous data phase done)
S_HREADYOUT  out  1  slave ready
S_HRDATA  out  32  read data
S_HRESP  out  1  0=OKAY, 1=ERROR
TOHOST_VALID  out  1  TOHOST_DATA holds an unconsumed value
TOHOST_READY  in  1  host accepts TOHOST_DATA
TOHOST_DATA  out  32  last value written to TOHOST
FROMHOST_VALID  in  1  host offers FROMHOST_IN
FROMHOST_READY  out  1  FROMHOST register empty (==0)
FROMHOST_IN  in  32  host data
TEST_DONE  out  1  sticky: a TOHOST write with bit0=1 occurred
TEST_PASS  out  1  sticky: that write was exactly 32'h1
SIG_BGN_OUT  out  32  signature begin address
SIG_END_OUT  out  32  signature end address

Behaviour:
- Reset is asynchronous and active-low on RES_N, with all state clocked on CLK. Reset values: S_HREADYOUT=1, S_HRESP=0, S_HRDATA=0, TOHOST_VALID=0, TOHOST_DATA=0, FROMHOST reg=0, TEST_DONE=0, TEST_PASS=0, SIG_BGN/END=parameters.
- Register map (offset = HADDR[ADDR_BITS-1:0]):
  - 0x00 TOHOST: RW.
  - 0x04 FROMHOST: RW.
  - 0x08 STATUS: RO; {28'b0, fromhost_full, tohost_valid, pass, done}.
  - 0x0C SIG_BGN: RW.
  - 0x10 SIG_END: RW.
  - Others: read 0, write ignored, OKAY.
- Address phase is captured when S_HSEL & S_HTRANS[1] & S_HREADY. Captured fields: offset, write, size.
- Data-phase FSM, states IDLE, ACCESS, WAIT, ERR1, ERR2:
  - IDLE->ACCESS on a valid capture.
  - ACCESS with size!=3'b010 -> ERR1: HREADYOUT=0, HRESP=1. ERR1->ERR2: HREADYOUT=1, HRESP=1. ERR2->IDLE/ACCESS. No register change on an errored transfer.
  - ACCESS, write TOHOST while TOHOST_VALID=1 and not (TOHOST_READY) -> WAIT, HREADYOUT=0. Stay in WAIT until the TOHOST_READY handshake occurs; on that cycle, accept the new data.
  - Otherwise zero wait state: reads drive HRDATA in the data phase; writes commit at the data-phase end using HWDATA.
- TOHOST write:
  - TOHOST_DATA<=HWDATA and TOHOST_VALID<=1.
  - If HWDATA[0]=1 and TEST_DONE=0: TEST_DONE<=1 and TEST_PASS<=(HWDATA==32'h1). TEST_DONE stays set until reset; later writes never change PASS.
  - TOHOST_VALID clears on VALID&READY unless a new write commits in the same cycle; in that case VALID stays 1 with the new data.
- FROMHOST:
  - FROMHOST_READY = (reg==0).
  - A host handshake (VALID&READY) loads FROMHOST_IN.
  - A CPU write loads HWDATA; writing 0 acknowledges.
  - A simultaneous CPU write and host load: CPU write wins.
- A back-to-back pipelined address phase is captured whenever HREADYOUT=1.
- A reset mid-WAIT aborts the transfer; the pending data is discarded.

Optional Feature:
HOST_MAILBOX_IRQ_EN:
- Defined: adds output port IRQ_FROMHOST (1 bit) = registered (FROMHOST reg != 0), reset 0. STATUS[4] mirrors it.
- Undefined: port absent, STATUS[4]=0.

Decomposition:
- Shared package: register offset constants, the STATUS bit indices, HTRANS/HSIZE/HRESP encodings, and the FSM state encoding.
- One sub-module is natural: ahb_host_mailbox_regs, holding the register file, TOHOST handshake and sticky status. The top handles AHB capture and the FSM.

Test Plan:
- Write 32'h1 to 0x00 with TOHOST_READY=1 -> zero wait, TOHOST_VALID pulses 1 cycle with DATA=1, TEST_DONE=1, TEST_PASS=1, STATUS reads 0x3.
- Write 32'h0000_002B to 0x00 -> TEST_DONE=1, TEST_PASS=0. A following write of 32'h1 leaves PASS=0.
- TOHOST_READY=0, two back-to-back TOHOST writes (0x10, 0x20) -> second data phase has HREADYOUT=0. Raise READY after 5 cycles -> HREADYOUT returns 1 the same cycle and TOHOST_DATA=0x20.
- Halfword write to 0x0C -> two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1), SIG_BGN unchanged.
- Host offers 0xA5 -> CPU reads 0x04 = 0xA5 and FROMHOST_READY=0. CPU writes 0 -> READY=1. With IRQ_EN, IRQ_FROMHOST follows the register.
- Assert RES_N low during WAIT -> all outputs return to reset values within the same cycle, and the next transfer completes normally.
